// File: rtl/alu_seq_xlen_if.sv
// Handshake/operand bundle for alu_seq_xlen.
// master: the core side. It drives the operation request and takes the result.
// slave : the ALU side.
//   in_valid/in_ready   request handshake (op, src_a, src_b)
//   out_valid/out_ready response handshake (result, zero, less)
interface alu_seq_xlen_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            less;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, less
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, less
  );
endinterface

// File: rtl/alu_seq_xlen.sv
// Handshaked, width-generic ALU sitting between the register-file read ports
// and the writeback mux.
//
// Single-cycle ops:
//   add, sub, and, srl, add_v, avg_v, slt and undefined codes.
//   Each returns its result one edge after accept.
// Iterative ops:
//   mul and mulhu use shift-add; divu and remu use restoring division.
//   Each returns its result XLEN+1 edges after accept.
//
// Ports:
//   clk   rising-edge clock
//   reset synchronous, active-high
//   bus   alu_seq_xlen_if.slave; request and response handshakes
//
// Parameters:
//   XLEN   must be >= 8 and a power of two.
//   LANE_W must divide XLEN.

// One packed lane. The sum is kept at LANE_W+1 bits so avg_v retains the carry.
module alu_seq_lane #(parameter int LANE_W = 8) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] sum,
  output logic [LANE_W-1:0] avg
);
  logic [LANE_W:0] wide;
  assign wide = {1'b0, a} + {1'b0, b};
  assign sum  = wide[LANE_W-1:0];
  assign avg  = wide[LANE_W:1];
endmodule

module alu_seq_xlen #(
  parameter int XLEN   = 32,
  parameter int LANE_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_xlen_if.slave bus
);
  localparam int NUM_LANES = XLEN / LANE_W;
  localparam int SHW       = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [3:0]        op_q;
  logic [XLEN-1:0]   b_q;       // multiplicand / divisor
  logic              less_q;
  logic [SHW-1:0]    cnt;
  logic [2*XLEN-1:0] acc;       // mul: {partial, multiplier}; div: {rem, quotient}
  logic [XLEN-1:0]   result_q;
  logic              zero_q;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.less      = less_q;

  // Packed-lane datapath
  logic [NUM_LANES-1:0][LANE_W-1:0] a_ln, b_ln, sum_ln, avg_ln;
  assign a_ln = bus.src_a;
  assign b_ln = bus.src_b;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    alu_seq_lane #(.LANE_W(LANE_W)) u_lane (
      .a   (a_ln[i]),
      .b   (b_ln[i]),
      .sum (sum_ln[i]),
      .avg (avg_ln[i])
    );
  end

  // Single-cycle result is formed straight from the inputs at accept.
  logic            less_in;
  logic            is_multi;
  logic [XLEN-1:0] single_res;

  assign less_in  = $signed(bus.src_a) < $signed(bus.src_b);
  assign is_multi = (bus.op[3:2] == 2'b10);

  always_comb begin
    single_res = '0;
    case (bus.op)
      4'b0000: single_res = bus.src_a + bus.src_b;
      4'b0001: single_res = bus.src_a - bus.src_b;
      4'b0010: single_res = bus.src_a & bus.src_b;
      4'b0011: single_res = bus.src_a >> bus.src_b[SHW-1:0];
      4'b0100: single_res = sum_ln;
      4'b0101: single_res = avg_ln;
      4'b0110: single_res = {{(XLEN-1){1'b0}}, less_in};
      default: single_res = '0;
    endcase
  end

  // One iteration step.
  // Shift-add: add the multiplicand into the upper half when the LSB is set,
  // then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring division.
  // The trial is two bits wider than the remainder, so a zero divisor never
  // reports a borrow. That yields an all-ones quotient, and the remainder
  // collects the dividend bits unchanged.
  logic [XLEN+1:0]   div_trial;
  logic [2*XLEN-1:0] div_next;
  assign div_trial = {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {2'b00, b_q};
  assign div_next  = div_trial[XLEN+1] ? {acc[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  // The low half holds mul / divu; the high half holds mulhu / remu.
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   multi_res;
  assign acc_next  = op_q[1] ? div_next : mul_next;
  assign multi_res = op_q[0] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      b_q      <= '0;
      less_q   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q   <= bus.op;
          b_q    <= bus.src_b;
          less_q <= less_in;
          cnt    <= '0;
          if (is_multi) begin
            acc   <= {{XLEN{1'b0}}, bus.src_a};
            state <= BUSY;
          end else begin
            result_q <= single_res;
            zero_q   <= (single_res == '0);
            state    <= DONE;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == SHW'(XLEN - 1)) begin
            result_q <= multi_res;
            zero_q   <= (multi_res == '0);
            state    <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_xlen.sv
module tb_alu_seq_xlen;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_seq_xlen_if #(.XLEN(32)) bus ();

  alu_seq_xlen #(.XLEN(32), .LANE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation end to end; reports latency (edges after accept) and
  // how many samples from accept to DONE saw in_ready high.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic l,
                        output int lat, output int rdy_hi);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin step(); w++; end
    bus.op = o; bus.src_a = a; bus.src_b = b; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.src_a = 32'hDEAD_BEEF; bus.src_b = 32'h1234_5678;
    lat = 1; rdy_hi = 0;
    if (bus.in_ready) rdy_hi++;
    while (!bus.out_valid && lat < 200) begin
      step(); lat++;
      if (bus.in_ready) rdy_hi++;
    end
    r = bus.result; z = bus.zero; l = bus.less;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", bus.result); end
    n_checks++; if ({bus.zero, bus.less} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b exp 00", {bus.zero, bus.less}); end
  endtask

  task automatic test_single();
    logic [31:0] r; logic z, l; int lat, rh;
    run_op(4'b0000, 32'd5, 32'hFFFF_FFFD, r, z, l, lat, rh);
    n_checks++; if (r !== 32'h2) begin n_fail++; $display("FAIL add_result got %h exp 00000002", r); end
    n_checks++; if ({z, l} !== 2'b00) begin n_fail++; $display("FAIL add_flags got %b exp 00", {z, l}); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d exp 1", lat); end
    run_op(4'b0001, 32'd7, 32'd7, r, z, l, lat, rh);
    n_checks++; if ({r, z} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL sub_zero got %h/%b exp 0/1", r, z); end
    run_op(4'b0010, 32'hFF80_0102, 32'hFF80_0304, r, z, l, lat, rh);
    n_checks++; if (r !== 32'hFF80_0100) begin n_fail++; $display("FAIL and got %h exp ff800100", r); end
    run_op(4'b0011, 32'h8000_0000, 32'd33, r, z, l, lat, rh);
    n_checks++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL srl got %h exp 40000000", r); end
    run_op(4'b0110, 32'hFFFF_FFFF, 32'd1, r, z, l, lat, rh);
    n_checks++; if ({r, l} !== {32'h1, 1'b1}) begin n_fail++; $display("FAIL slt_neg got %h/%b exp 1/1", r, l); end
    run_op(4'b0110, 32'd1, 32'hFFFF_FFFF, r, z, l, lat, rh);
    n_checks++; if ({r, z, l} !== {32'h0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL slt_pos got %h/%b/%b exp 0/1/0", r, z, l); end
    run_op(4'b0111, 32'd9, 32'd9, r, z, l, lat, rh);
    n_checks++; if ({r, z} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL undef_op got %h/%b exp 0/1", r, z); end
  endtask

  task automatic test_lanes();
    logic [31:0] r; logic z, l; int lat, rh;
    run_op(4'b0101, 32'hFF80_0102, 32'hFF80_0304, r, z, l, lat, rh);
    n_checks++; if (r !== 32'hFF80_0203) begin n_fail++; $display("FAIL avg_v got %h exp ff800203", r); end
    run_op(4'b0100, 32'hFF80_0102, 32'hFF80_0304, r, z, l, lat, rh);
    n_checks++; if (r !== 32'hFE00_0406) begin n_fail++; $display("FAIL add_v got %h exp fe000406", r); end
  endtask

  task automatic test_mul();
    logic [31:0] r; logic z, l; int lat, rh;
    run_op(4'b1000, 32'h0001_0000, 32'h0001_0000, r, z, l, lat, rh);
    n_checks++; if ({r, z} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL mul_lo got %h/%b exp 0/1", r, z); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency got %0d exp 33", lat); end
    n_checks++; if (rh !== 0) begin n_fail++; $display("FAIL mul_in_ready_busy got %0d exp 0", rh); end
    run_op(4'b1001, 32'h0001_0000, 32'h0001_0000, r, z, l, lat, rh);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL mulhu got %h exp 00000001", r); end
    run_op(4'b1000, 32'd7, 32'd6, r, z, l, lat, rh);
    n_checks++; if (r !== 32'd42) begin n_fail++; $display("FAIL mul_small got %h exp 0000002a", r); end
    run_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, l, lat, rh);
    n_checks++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_max got %h exp fffffffe", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; logic z, l; int lat, rh;
    run_op(4'b1010, 32'd100, 32'd7, r, z, l, lat, rh);
    n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu got %h exp 0000000e", r); end
    run_op(4'b1011, 32'd100, 32'd7, r, z, l, lat, rh);
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu got %h exp 00000002", r); end
    run_op(4'b1010, 32'd100, 32'd0, r, z, l, lat, rh);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero got %h exp ffffffff", r); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_zero_latency got %0d exp 33", lat); end
    run_op(4'b1011, 32'd100, 32'd0, r, z, l, lat, rh);
    n_checks++; if (r !== 32'd100) begin n_fail++; $display("FAIL remu_zero got %h exp 00000064", r); end
    run_op(4'b1011, 32'hFFFF_FFFF, 32'd0, r, z, l, lat, rh);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL remu_zero_max got %h exp ffffffff", r); end
    run_op(4'b1010, 32'hFFFF_FFFF, 32'd1, r, z, l, lat, rh);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by_one got %h exp ffffffff", r); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic z, l; int lat, rh, w;
    bus.op = 4'b0000; bus.src_a = 32'd1; bus.src_b = 32'd2; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 50) begin step(); w++; end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0); bus.op = 4'b0000;
      bus.src_a = 32'd100; bus.src_b = 32'd100 + i;
      step();
      n_checks++; if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b1, 1'b0, 32'd3}) begin
        n_fail++; $display("FAIL stall_%0d got v%b r%b %h exp v1 r0 00000003", i, bus.out_valid, bus.in_ready, bus.result);
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin n_fail++; $display("FAIL release got rdy/vld %b exp 10", {bus.in_ready, bus.out_valid}); end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL no_queued_op got out_valid %b exp 0", bus.out_valid); end
    run_op(4'b0000, 32'd10, 32'd20, r, z, l, lat, rh);
    n_checks++; if (r !== 32'd30) begin n_fail++; $display("FAIL after_stall got %h exp 0000001e", r); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    bus.op = 4'b0000; bus.src_a = 32'd1; bus.src_b = 32'd1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.out_valid) pulses++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    step();
    n_checks++; if (pulses !== 3) begin n_fail++; $display("FAIL back_to_back got %0d results exp 3", pulses); end
    n_checks++; if (bus.result !== 32'd2) begin n_fail++; $display("FAIL back_to_back_result got %h exp 00000002", bus.result); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic z, l; int lat, rh, spurious;
    bus.op = 4'b1000; bus.src_a = 32'd3; bus.src_b = 32'd5; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_fail++; $display("FAIL midreset_hs got vld/rdy %b exp 01", {bus.out_valid, bus.in_ready}); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL midreset_result got %h exp 0", bus.result); end
    spurious = 0;
    for (int i = 0; i < 35; i++) begin step(); if (bus.out_valid) spurious++; end
    n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL midreset_spurious got %0d exp 0", spurious); end
    run_op(4'b0000, 32'd3, 32'd4, r, z, l, lat, rh);
    n_checks++; if ({r, lat} !== {32'd7, 32'd1}) begin n_fail++; $display("FAIL post_reset_add got %h lat %0d exp 00000007 lat 1", r, lat); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lanes();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq_xlen.md
Name: alu_seq_xlen

Overview:
Parametrised, handshaked successor to the single-cycle 32-bit ALU. It is generic in datapath width (XLEN) and packed-lane width (LANE_W), and adds iterative multi-cycle multiply/divide (mul, mulhu, divu, remu) plus an explicit slt result. It sits between the register-file read ports and the writeback mux. A valid/ready pair on each side lets the core stall while a long operation is in flight.

Parameters:
XLEN, 32, datapath width; must be ≥ 8 and a power of two.
LANE_W, 8, packed-lane width for add_v/avg_v; must divide XLEN exactly.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  op, src_a, src_b are valid
in_ready  output  1  block can accept an operation this cycle
op  input  4  operation select (encoding below)
src_a  input  XLEN  operand A
src_b  input  XLEN  operand B
out_valid  output  1  result/flags valid and held stable
out_ready  input  1  consumer takes the result this cycle
result  output  XLEN  registered result
zero  output  1  result == 0
less  output  1  $signed(src_a) < $signed(src_b), captured at accept

Behaviour:
- Op encoding:
  - 0000 add; 0001 sub; 0010 and.
  - 0011 srl: shift by src_b[log2(XLEN)-1:0].
  - 0100 add_v: per-lane sum, modulo 2^LANE_W.
  - 0101 avg_v: per-lane (a+b)>>1, computed at LANE_W+1 bits so the carry is kept.
  - 0110 slt: result = {XLEN-1 zeros, less}.
  - 1000 mul: low XLEN bits of unsigned product.
  - 1001 mulhu: high XLEN bits of unsigned product.
  - 1010 divu; 1011 remu.
  - All other codes: result 0.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state == IDLE); out_valid = (state == DONE). Both are pure state decodes, with no combinational path from in_valid or out_ready.
- Accept: in_valid && in_ready at a rising edge. Operands, op and less are captured in internal registers at accept. Input changes after accept have no effect.
- Single-cycle ops (0000–0110 and undefined codes): IDLE → DONE. out_valid rises on the edge after accept (latency 1).
- Multi-cycle ops (1000–1011): IDLE → BUSY with iteration counter = 0.
  - mul/mulhu: shift-add, one bit per cycle, 2·XLEN-bit accumulator.
  - divu/remu: restoring division, one quotient bit per cycle.
  - After XLEN BUSY cycles → DONE. out_valid rises exactly XLEN+1 edges after accept (33 for XLEN=32).
- Divide by zero: still takes XLEN+1 cycles. divu returns all ones; remu returns src_a.
- DONE: result, zero and less stay stable while out_ready = 0, for unbounded stall. When out_ready = 1: DONE → IDLE. in_ready is 1 on the following cycle, giving at most one op per two cycles for single-cycle ops.
- zero is computed from the final result and registered with it. less is the value captured at accept.
- Reset (any state, including mid-BUSY):
  - Next state is IDLE; the in-flight op is discarded and no out_valid pulse occurs.
  - result = 0, zero = 0, less = 0, counter = 0, internal accumulators = 0.
  - in_ready = 1 on the first cycle after reset deasserts.
- in_valid while BUSY or DONE is ignored; the op is not queued.
- out_ready while not in DONE is ignored.

Test Plan:
- add: src_a = 5, src_b = 0xFFFFFFFD → result = 0x00000002, zero = 0, less = 0, out_valid 1 cycle after accept. sub: 7 − 7 → result 0, zero = 1.
- avg_v/add_v: a = 0xFF800102, b = 0xFF800304.
  - avg_v → 0xFF800203 (carry kept).
  - add_v → 0xFE000406.
  - srl: a = 0x80000000, b = 33 → 0x40000000.
- mul: a = b = 0x00010000.
  - mul → result 0, zero = 1, out_valid exactly 33 edges after accept, in_ready = 0 throughout BUSY.
  - mulhu with the same operands → 0x00000001.
- Divide:
  - divu 100/7 → 14; remu 100/7 → 2.
  - divu 100/0 → 0xFFFFFFFF; remu 100/0 → 100.
  - slt: a = −1, b = 1 → result 1, less = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after DONE, while toggling in_valid with new operands.
  - result is unchanged and in_ready = 0 for all 5 cycles.
  - After out_ready = 1: in_ready = 1 next cycle, and only subsequently presented ops are executed.
- Reset mid-op: assert reset during BUSY cycle 10 of a mul.
  - Next cycle: out_valid = 0, in_ready = 1, result = 0.
  - A following add 3+4 returns 7 with correct latency.
